// File: rtl/if_id_stage_if.sv
// Hazard-facing bus of the fetch stage: hazard/branch controls in, IF/ID contents and perf counters out.
// The master side is the surrounding pipeline; the slave side is if_id_stage itself.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic              pc_write;
  logic              ifid_write;
  logic              flush;
  logic [31:0]       branch_target;
  logic [31:0]       instr_in;
  logic [31:0]       imem_addr;
  logic [31:0]       pc_plus4_id;
  logic [31:0]       instr_id;
  logic              valid_id;
  logic [4:0]        rs_id;
  logic [4:0]        rt_id;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output pc_write, ifid_write, flush, branch_target, instr_in,
    input  imem_addr, pc_plus4_id, instr_id, valid_id, rs_id, rt_id,
           stall_count, flush_count
  );

  modport slave (
    input  pc_write, ifid_write, flush, branch_target, instr_in,
    output imem_addr, pc_plus4_id, instr_id, valid_id, rs_id, rt_id,
           stall_count, flush_count
  );
endinterface

// File: rtl/if_id_stage.sv
// PC register plus IF/ID latch; one-cycle fetch latency, stalls by holding on pc_write/ifid_write low.
// Flush redirects PC and squashes IF/ID; saturating stall/flush counters for perf debug.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  if_id_stage_if.slave ifid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      instr_q;
  logic [31:0]      pc_plus4_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_plus4_q  <= 32'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ifid.flush) begin
        pc <= {ifid.branch_target[31:2], 2'b00};
      end else if (ifid.pc_write) begin
        pc <= pc_plus4;
      end

      if (ifid.flush) begin
        instr_q    <= NOP_INSTR;
        pc_plus4_q <= 32'd0;
        valid_q    <= 1'b0;
      end else if (ifid.ifid_write) begin
        instr_q    <= ifid.instr_in;
        pc_plus4_q <= pc_plus4;
        valid_q    <= 1'b1;
      end

      // Only stalls that hold a real instruction count; bubbles sitting in ID are free.
      if (!ifid.ifid_write && !ifid.flush && valid_q && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid.flush && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign ifid.imem_addr   = pc;
  assign ifid.instr_id    = instr_q;
  assign ifid.pc_plus4_id = pc_plus4_q;
  assign ifid.valid_id    = valid_q;
  // Bubbles present register 0 so the hazard unit never matches on them.
  assign ifid.rs_id       = valid_q ? instr_q[25:21] : 5'd0;
  assign ifid.rt_id       = valid_q ? instr_q[20:16] : 5'd0;
  assign ifid.stall_count = stall_cnt_q;
  assign ifid.flush_count = flush_cnt_q;

endmodule
